timer_dev: RTL and testbench
============================

Name: timer_dev

Overview:
Programmable countdown timer. It is a responder on the processor data bus, the device end of the CPU's PrAddr/PrWD/PrBE/PrWE/PrRD interface. The system bridge decodes the address, drives sel, and routes rd back onto PrRD. The irq output feeds one bit of the CPU's HWInt[7:2] vector.

Parameters:
CNT_W, 32, width of PRESET and COUNT (1..32); reads zero-extend to 32 bits.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
sel  input  1  device selected by the bridge for the current bus access
addr  input  2  word address within the device (PrAddr[3:2])
we  input  1  write strobe; qualified by sel
be  input  4  byte enables for writes (PrBE)
wd  input  32  write data (PrWD)
rd  output  32  read data, combinational, zero latency
irq  output  1  interrupt request to HWInt

Behaviour:
- Register map (word offset):
  - 0 CTRL: bit0 EN, bits2:1 MODE, bit3 IM; other bits read 0.
  - 1 PRESET: read/write.
  - 2 COUNT: read-only; writes ignored.
  - 3: reads 0; writes ignored.
- Writes
  - Take effect at the rising edge when sel & we.
  - Byte-merged per be: byte i is written only when be[i]=1.
- Reads
  - rd = register[addr] when sel=1, else 0.
  - Purely combinational, so the CPU's M-stage load sees the data in the same cycle.
- Reset (rst=0, asynchronous):
  - CTRL=0, PRESET=0, COUNT=0, flag=0, state=IDLE.
  - rd follows the combinational rule above; irq=0.
  - Reset mid-count aborts the count immediately.
- MODE encodings
  - 00: one-shot, sticky interrupt.
  - 01: auto-reload, one-cycle interrupt pulse.
  - 1x: reserved; behaves as 00.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT, EN=0: -> IDLE; COUNT holds its value.
  - CNT, COUNT>1: COUNT<=COUNT-1, stay in CNT.
  - CNT, COUNT<=1 (includes PRESET=0): COUNT<=0, flag<=1 -> INT.
  - INT, MODE 00: EN<=0 -> IDLE; flag stays set.
  - INT, MODE 01: flag<=0 -> LOAD (reload).
- Interrupt flag and irq
  - irq = flag & IM, registered-flag based and glitch-free.
  - MODE 00: flag clears on any bus write to CTRL or PRESET.
  - MODE 01: flag is high for exactly the one cycle spent in INT.
- Latency and period
  - Write EN=1 at edge 0: LOAD after edge 1, COUNT=P after edge 2.
  - COUNT decrements 1 per edge; COUNT=0, INT and irq high after edge P+2 (P>=1).
  - MODE 01 period: P+2 cycles per interrupt.
- Writes while counting
  - A PRESET write while in CNT does not change COUNT; it is used at the next LOAD.
  - A CTRL write with EN=0 while in CNT moves to IDLE at the next edge.
- Simultaneous events
  - Bus write to CTRL in the same cycle as INT clearing EN: the bus write wins (EN keeps the written value). The FSM still goes INT->IDLE; if the written EN=1 it proceeds IDLE->LOAD.
  - Flag set (CNT->INT) in the same cycle as a clearing write: set wins.
- Decrement arithmetic is CNT_W-bit unsigned with no wrap; the guard COUNT<=1 prevents underflow.

Decomposition:
- Shared package timer_pkg:
  - Register offsets (CTRL/PRESET/COUNT).
  - CTRL bit positions.
  - MODE encodings.
  - FSM state encoding.
  - Byte-enable merge function (old, new, be -> merged).
- No sub-module; the FSM, register file and read mux are a single module.

Test Plan:
- Reset during CNT with COUNT=3 -> after reset all reads 0, irq=0, state IDLE.
- PRESET=5, CTRL=0x9 (EN, MODE 00, IM) -> COUNT reads 5,4,3,2,1,0 on successive cycles; irq rises after edge 7 and stays high; CTRL reads 0x8. A write of CTRL=0x8 drops irq next cycle.
- PRESET=3, CTRL=0xB (MODE 01, IM) -> irq one-cycle pulses every 5 cycles; COUNT reloads to 3 each period; EN stays 1.
- Byte write PRESET with be=0010, wd=0xAABBCCDD onto 0x11223344 -> PRESET reads 0x1122CC44. Write to COUNT -> no change. Read addr 3 -> 0. Read with sel=0 -> 0.
- Mid-count CTRL=0x0 at COUNT=4 -> COUNT holds 4, no irq. Re-enable -> reloads PRESET via LOAD.
- PRESET=0 enable -> INT two edges after LOAD (immediately from CNT). CTRL write EN=1 coinciding with INT in MODE 00 -> EN reads 1, counting restarts via IDLE->LOAD.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: register map, CTRL fields,
// mode and FSM encodings, and the byte-enable merge helper.
package timer_pkg;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++)
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// Programmable countdown timer on the processor data bus: CTRL/PRESET/COUNT
// registers, a four-state count FSM and a combinational zero-latency read mux.
module timer_dev
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    output logic             irq
);

    state_t             state, state_nxt;
    logic               en, im, flag;
    logic [1:0]         mode;
    logic [CNT_W-1:0]   preset, count;
    logic [31:0]        preset_merged;

    logic wr_ctrl, wr_pre, one_shot, cnt_gt1;
    logic ld_count, dec_count, zero_count, set_flag, int_clr_en, int_clr_flag;

    assign wr_ctrl       = sel & we & (addr == A_CTRL);
    assign wr_pre        = sel & we & (addr == A_PRESET);
    // Reserved modes (1x) fall back to one-shot behaviour.
    assign one_shot      = (mode != MODE_RELOAD);
    assign cnt_gt1       = (count > CNT_W'(1));
    assign preset_merged = be_merge(32'(preset), wd, be);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_CNT;
            ST_CNT: begin
                if (!en)          state_nxt = ST_IDLE;
                else if (!cnt_gt1) state_nxt = ST_INT;
            end
            ST_INT:  state_nxt = one_shot ? ST_IDLE : ST_LOAD;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ld_count     = 1'b0;
        dec_count    = 1'b0;
        zero_count   = 1'b0;
        set_flag     = 1'b0;
        int_clr_en   = 1'b0;
        int_clr_flag = 1'b0;
        case (state)
            ST_LOAD: ld_count = 1'b1;
            ST_CNT: begin
                if (en) begin
                    if (cnt_gt1) dec_count = 1'b1;
                    else begin
                        zero_count = 1'b1;
                        set_flag   = 1'b1;
                    end
                end
            end
            ST_INT: begin
                if (one_shot) int_clr_en   = 1'b1;
                else          int_clr_flag = 1'b1;
            end
            default: ;
        endcase
    end

    // Bus writes to CTRL override the FSM's EN clear; a flag set overrides clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en     <= 1'b0;
            mode   <= MODE_ONESHOT;
            im     <= 1'b0;
            preset <= '0;
            count  <= '0;
            flag   <= 1'b0;
        end else begin
            if (wr_ctrl && be[0]) begin
                en   <= wd[CTRL_EN];
                mode <= wd[CTRL_MODE_HI:CTRL_MODE_LO];
                im   <= wd[CTRL_IM];
            end else if (int_clr_en) begin
                en <= 1'b0;
            end
            if (wr_pre) preset <= preset_merged[CNT_W-1:0];
            if (ld_count)        count <= preset;
            else if (dec_count)  count <= count - CNT_W'(1);
            else if (zero_count) count <= '0;
            if (set_flag)                               flag <= 1'b1;
            else if (int_clr_flag || wr_ctrl || wr_pre) flag <= 1'b0;
        end
    end

    always_comb begin
        rd = '0;
        if (sel) begin
            case (addr)
                A_CTRL: begin
                    rd[CTRL_EN]                    = en;
                    rd[CTRL_MODE_HI:CTRL_MODE_LO]  = mode;
                    rd[CTRL_IM]                    = im;
                end
                A_PRESET: rd = 32'(preset);
                A_COUNT:  rd = 32'(count);
                default:  rd = '0;
            endcase
        end
    end

    assign irq = flag & im;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios plus random bus traffic
// checked against a cycle-level behavioural model of the timer.
module tb_timer_dev;

    logic        clk, rst, sel, we, irq;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd, rd;

    int n_cmp = 0;
    int n_bad = 0;

    timer_dev #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .sel(sel), .addr(addr), .we(we),
        .be(be), .wd(wd), .rd(rd), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 load, 2 counting, 3 interrupt.
    logic        m_en, m_im, m_flag;
    logic [1:0]  m_mode;
    logic [31:0] m_preset, m_count;
    int          m_ph;

    function automatic logic [31:0] exp_rd(input logic [1:0] a, input logic s);
        if (!s) return 32'd0;
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_im = 0; m_flag = 0; m_mode = 0;
        m_preset = 0; m_count = 0; m_ph = 0;
    endtask

    task automatic tick(input logic s, input logic w, input logic [1:0] a,
                        input logic [3:0] b, input logic [31:0] d);
        logic        n_en, n_im, n_flag, wr_c, wr_p, one;
        logic [1:0]  n_mode;
        logic [31:0] n_pre, n_cnt;
        int          n_ph;
        sel = s; we = w; addr = a; be = b; wd = d;
        wr_c = s && w && (a == 2'd0);
        wr_p = s && w && (a == 2'd1);
        one  = (m_mode != 2'b01);
        n_en = m_en; n_im = m_im; n_mode = m_mode; n_flag = m_flag;
        n_pre = m_preset; n_cnt = m_count; n_ph = m_ph;
        if (wr_c || wr_p) n_flag = 0;
        case (m_ph)
            0: if (m_en) n_ph = 1;
            1: begin n_cnt = m_preset; n_ph = 2; end
            2: begin
                if (!m_en) n_ph = 0;
                else if (m_count > 1) n_cnt = m_count - 1;
                else begin n_cnt = 0; n_flag = 1; n_ph = 3; end
            end
            default: begin
                if (one) begin n_en = 0; n_ph = 0; end
                else begin n_flag = 0; n_ph = 1; end
            end
        endcase
        if (wr_c && b[0]) begin n_en = d[0]; n_mode = d[2:1]; n_im = d[3]; end
        if (wr_p)
            for (int i = 0; i < 4; i++)
                if (b[i]) n_pre[8*i +: 8] = d[8*i +: 8];
        @(posedge clk);
        m_en = n_en; m_im = n_im; m_mode = n_mode; m_flag = n_flag;
        m_preset = n_pre; m_count = n_cnt; m_ph = n_ph;
        @(negedge clk);
        sel = 1; we = 0; addr = 2'd2; be = 0; wd = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        model_reset();
        @(negedge clk);
        rst = 1;
        sel = 1; we = 0; addr = 2'd2; be = 0; wd = 0;
    endtask

    task automatic test_reset();
        int guard;
        #1;
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a); #1;
            n_cmp++; if (rd !== 32'd0) $display("FAIL reset_rd a=%0d got=%h exp=0", a, rd);
            if (rd !== 32'd0) n_bad++;
        end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        @(negedge clk); rst = 1; model_reset();
        tick(1, 1, 2'd1, 4'hF, 32'd5);
        tick(1, 1, 2'd0, 4'hF, 32'h9);
        guard = 0;
        while (!(m_ph == 2 && m_count == 3) && guard < 20) begin tick(1, 0, 2'd2, 0, 0); guard++; end
        n_cmp++; if (guard >= 20) begin n_bad++; $display("FAIL reset_setup timeout got=%0d exp=<20", guard); end
        #2 rst = 0; model_reset();
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a); #1;
            n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL midreset_rd a=%0d got=%h exp=0", a, rd); end
        end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL midreset_irq got=%b exp=0", irq); end
        @(negedge clk); rst = 1;
        for (int k = 0; k < 3; k++) begin
            tick(1, 0, 2'd2, 0, 0); #1;
            n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL postreset_count got=%h exp=0", rd); end
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] e;
        do_reset();
        tick(1, 1, 2'd1, 4'hF, 32'd5);
        tick(1, 1, 2'd0, 4'hF, 32'h9);
        for (int k = 1; k <= 8; k++) begin
            tick(1, 0, 2'd2, 0, 0); #1;
            e = (k < 2) ? 32'd0 : (k < 7) ? 32'(7 - k) : 32'd0;
            n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL oneshot_count k=%0d got=%h exp=%h", k, rd, e); end
            n_cmp++; if (rd !== exp_rd(2'd2, 1'b1)) begin n_bad++; $display("FAIL oneshot_model k=%0d got=%h exp=%h", k, rd, exp_rd(2'd2, 1'b1)); end
            n_cmp++; if (irq !== (k >= 7)) begin n_bad++; $display("FAIL oneshot_irq k=%0d got=%b exp=%b", k, irq, k >= 7); end
        end
        addr = 2'd0; #1;
        n_cmp++; if (rd !== 32'h8) begin n_bad++; $display("FAIL oneshot_ctrl got=%h exp=8", rd); end
        tick(1, 1, 2'd0, 4'hF, 32'h8); #1;
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL oneshot_irqclr got=%b exp=0", irq); end
    endtask

    task automatic test_autoreload();
        do_reset();
        tick(1, 1, 2'd1, 4'hF, 32'd3);
        tick(1, 1, 2'd0, 4'hF, 32'hB);
        for (int k = 1; k <= 22; k++) begin
            tick(1, 0, 2'd2, 0, 0); #1;
            n_cmp++; if (irq !== (k % 5 == 0)) begin n_bad++; $display("FAIL reload_irq k=%0d got=%b exp=%b", k, irq, k % 5 == 0); end
            n_cmp++; if (rd !== exp_rd(2'd2, 1'b1)) begin n_bad++; $display("FAIL reload_count k=%0d got=%h exp=%h", k, rd, exp_rd(2'd2, 1'b1)); end
            if (k % 5 == 2) begin
                n_cmp++; if (rd !== 32'd3) begin n_bad++; $display("FAIL reload_value k=%0d got=%h exp=3", k, rd); end
            end
        end
        addr = 2'd0; #1;
        n_cmp++; if (rd !== 32'hB) begin n_bad++; $display("FAIL reload_ctrl got=%h exp=b", rd); end
    endtask

    task automatic test_bus_access();
        do_reset();
        tick(1, 1, 2'd1, 4'hF, 32'h11223344);
        tick(1, 1, 2'd1, 4'b0010, 32'hAABBCCDD);
        addr = 2'd1; #1;
        n_cmp++; if (rd !== 32'h1122CC44) begin n_bad++; $display("FAIL byte_merge got=%h exp=1122cc44", rd); end
        tick(1, 1, 2'd2, 4'hF, 32'hDEADBEEF); #1;
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL count_ro got=%h exp=0", rd); end
        addr = 2'd3; #1;
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL addr3 got=%h exp=0", rd); end
        sel = 0; addr = 2'd1; #1;
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL nosel got=%h exp=0", rd); end
    endtask

    task automatic test_pause();
        int guard;
        do_reset();
        tick(1, 1, 2'd1, 4'hF, 32'd10);
        tick(1, 1, 2'd0, 4'hF, 32'h1);
        guard = 0;
        while (!(m_ph == 2 && m_count == 5) && guard < 30) begin tick(1, 0, 2'd2, 0, 0); guard++; end
        n_cmp++; if (guard >= 30) begin n_bad++; $display("FAIL pause_setup timeout got=%0d exp=<30", guard); end
        tick(1, 1, 2'd0, 4'hF, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick(1, 0, 2'd2, 0, 0); #1;
            n_cmp++; if (rd !== 32'd4) begin n_bad++; $display("FAIL pause_hold k=%0d got=%h exp=4", k, rd); end
            n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL pause_irq got=%b exp=0", irq); end
        end
        tick(1, 1, 2'd0, 4'hF, 32'h1);
        tick(1, 0, 2'd2, 0, 0);
        tick(1, 0, 2'd2, 0, 0); #1;
        n_cmp++; if (rd !== 32'd10) begin n_bad++; $display("FAIL pause_reload got=%h exp=a", rd); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick(1, 1, 2'd1, 4'hF, 32'd0);
        tick(1, 1, 2'd0, 4'hF, 32'h9);
        tick(1, 0, 2'd2, 0, 0);
        tick(1, 0, 2'd2, 0, 0);
        tick(1, 0, 2'd2, 0, 0); #1;
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL zero_preset_irq got=%b exp=1", irq); end
        tick(1, 1, 2'd0, 4'hF, 32'h9);
        addr = 2'd0; #1;
        n_cmp++; if (rd !== 32'h9) begin n_bad++; $display("FAIL collide_ctrl got=%h exp=9", rd); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL collide_irqclr got=%b exp=0", irq); end
        tick(1, 0, 2'd2, 0, 0);
        tick(1, 0, 2'd2, 0, 0);
        tick(1, 0, 2'd2, 0, 0); #1;
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL collide_restart got=%b exp=1", irq); end
    endtask

    task automatic test_random();
        int r;
        logic [1:0] a;
        logic s;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            a = 2'($urandom_range(0, 3));
            if (r < 2) do_reset();
            else if (r < 14) begin
                if (a == 2'd0) tick(1, 1, a, 4'($urandom_range(0, 15)), 32'($urandom_range(0, 15)));
                else           tick(1, 1, a, 4'($urandom_range(0, 15)), 32'($urandom_range(0, 7)) | ($urandom & 32'hFFFF_FF00 & {32{r[0]}}) & 32'h0);
            end else tick(1, 0, 2'd2, 0, 0);
            a = 2'($urandom_range(0, 3));
            s = ($urandom_range(0, 9) != 0);
            sel = s; addr = a; #1;
            n_cmp++; if (rd !== exp_rd(a, s)) begin n_bad++; $display("FAIL rand_rd i=%0d a=%0d got=%h exp=%h", i, a, rd, exp_rd(a, s)); end
            n_cmp++; if (irq !== (m_flag & m_im)) begin n_bad++; $display("FAIL rand_irq i=%0d got=%b exp=%b", i, irq, m_flag & m_im); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; sel = 0; we = 0; addr = 0; be = 0; wd = 0;
        model_reset();
        test_reset();
        test_oneshot();
        test_autoreload();
        test_bus_access();
        test_pause();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
